noc_credit_tx: RTL and testbench

//  Credit-based transmit stage directly downstream of the AXIS/NoC bridge and upstream of the router input port.

---
 rtl/noc_credit_tx.sv | 105 ++++++++++
 tb/tb_noc_credit_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_credit_tx.sv
// Credit-based transmit stage: buffers bridge flits in a small FIFO and launches
// at most one registered flit per cycle toward the router while a credit is held.
module noc_credit_tx #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4,
  localparam int CW = $clog2(CREDITS + 1),
  localparam int FW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] noc_data,
  output logic              noc_valid,
  input  logic              noc_credit,
  output logic [CW-1:0]     credits_avail,
  output logic [FW-1:0]     fifo_count,
  output logic              credit_err
);

  localparam logic [FW-1:0] DEPTH_C = FW'(DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]     count_q, count_d;
  logic [CW-1:0]     cred_q, cred_d;
  logic              err_q, err_d;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              push, send;

  // in_ready comes only from the registered count, so a full FIFO never
  // accepts in the same cycle that it pops.
  assign in_ready = (count_q < DEPTH_C);
  assign push     = in_valid & in_ready;
  assign send     = (count_q != '0) & (cred_q != '0);

  always_comb begin
    count_d = count_q;
    cred_d  = cred_q;
    err_d   = err_q;
    if (push & !send) begin
      count_d = count_q + 1'b1;
    end else if (!push & send) begin
      count_d = count_q - 1'b1;
    end
    // A credit returned in the same cycle as a send cancels out.
    if (send & !noc_credit) begin
      cred_d = cred_q - 1'b1;
    end else if (noc_credit & !send) begin
      if (cred_q == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        cred_d = cred_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cred_q   <= CRED_MAX;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      count_q <= count_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
      valid_q <= send;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (send) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        data_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign noc_data      = data_q;
  assign noc_valid     = valid_q;
  assign credits_avail = cred_q;
  assign fifo_count    = count_q;
  assign credit_err    = err_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    push |-> (count_q < DEPTH_C));
  a_valid_had_credit: assert property (@(posedge clk) disable iff (!rst)
    valid_q |-> ($past(cred_q) != '0));
  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count_q <= DEPTH_C);
  a_cred_bound: assert property (@(posedge clk) disable iff (!rst)
    cred_q <= CRED_MAX);

endmodule

// File: tb/tb_noc_credit_tx.sv
// Bench for noc_credit_tx: directed scenarios followed by random traffic, all
// compared against a queue-based transaction model of the transmit stage.
module tb_noc_credit_tx;
  localparam int DATA_W  = 64;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;
  localparam int CW = $clog2(CREDITS + 1);
  localparam int FW = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] noc_data;
  logic              noc_valid;
  logic              noc_credit = 1'b0;
  logic [CW-1:0]     credits_avail;
  logic [FW-1:0]     fifo_count;
  logic              credit_err;

  noc_credit_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .noc_data(noc_data), .noc_valid(noc_valid), .noc_credit(noc_credit),
    .credits_avail(credits_avail), .fifo_count(fifo_count), .credit_err(credit_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // reference model: FIFO contents, credit count, last launched flit
  logic [DATA_W-1:0] m_fifo[$];
  int                m_cred;
  bit                m_valid;
  logic [DATA_W-1:0] m_data;
  bit                m_err;
  logic [DATA_W-1:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  bit                s_valid, s_ready, s_err;
  logic [DATA_W-1:0] s_data;
  int                s_cred, s_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_cred  = CREDITS;
    m_valid = 1'b0;
    m_data  = '0;
    m_err   = 1'b0;
  endtask

  // one clock cycle: drive, sample at negedge, compare, advance the model
  task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit c);
    bit send, push;
    logic [DATA_W-1:0] e;
    in_valid   = v;
    in_data    = d;
    noc_credit = c;
    @(negedge clk);
    s_valid = noc_valid;
    s_ready = in_ready;
    s_err   = credit_err;
    s_data  = noc_data;
    s_cred  = int'(credits_avail);
    s_cnt   = int'(fifo_count);
    chk("in_ready", in_ready, (m_fifo.size() < DEPTH));
    chk("fifo_count", fifo_count, m_fifo.size());
    chk("credits_avail", credits_avail, m_cred);
    chk("noc_valid", noc_valid, m_valid);
    chk("noc_data", noc_data, m_data);
    chk("credit_err", credit_err, m_err);
    if (noc_valid === 1'b1) begin
      e = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk("sb_order", noc_data, e);
    end
    send = (m_fifo.size() != 0) && (m_cred != 0);
    push = v && (m_fifo.size() < DEPTH);
    if (send) begin
      m_data = m_fifo.pop_front();
      exp_q.push_back(m_data);
    end
    m_valid = send;
    if (push) m_fifo.push_back(d);
    m_cred = m_cred - int'(send) + int'(c);
    if (m_cred > CREDITS) begin
      m_cred = CREDITS;
      m_err  = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    noc_credit = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int pulses, first_p, last_p, idx;
    bit found, c, v, held;
    logic [DATA_W-1:0] d;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_noc_valid", noc_valid, 0);
    chk("rst_noc_data", noc_data, 0);
    chk("rst_credits", credits_avail, CREDITS);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_credit_err", credit_err, 0);
    rst = 1'b1;

    // single flit latency
    cycle(1, 64'hA5, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("t1_valid", s_valid, 1);
    chk("t1_data", s_data, 64'hA5);
    chk("t1_cred", s_cred, 3);
    cycle(0, 0, 0);

    // six flits, four credits
    do_reset();
    pulses = 0; first_p = -1; last_p = -1;
    for (int i = 0; i < 14; i++) begin
      cycle(i < 6, 64'h100 + i, 0);
      if (s_valid) begin
        pulses++;
        if (first_p < 0) first_p = i;
        last_p = i;
      end
    end
    chk("t2_pulses", pulses, 4);
    chk("t2_consecutive", last_p - first_p, 3);
    chk("t2_cred_zero", s_cred, 0);
    chk("t2_fifo_left", s_cnt, 2);
    chk("t2_valid_low", s_valid, 0);

    // credit returns release the remaining flits in order
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("t3_valid1", s_valid, 1);
    chk("t3_data1", s_data, 64'h104);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("t3_data2", s_data, 64'h105);
    cycle(0, 0, 0);
    chk("t3_empty", s_cnt, 0);

    // backpressure with no credits
    idx = 0;
    for (int n = 0; n < 20 && idx < 4; n++) begin
      cycle(1, 64'h200 + idx, 0);
      if (s_ready) idx++;
    end
    cycle(1, 64'h204, 0);
    chk("t4_ready_low", s_ready, 0);
    cycle(1, 64'h204, 1);
    cycle(1, 64'h204, 0);
    chk("t4_ready_low_pop", s_ready, 0);
    cycle(1, 64'h204, 0);
    chk("t4_ready_back", s_ready, 1);
    idx = 5;
    for (int n = 0; n < 60 && idx < 8; n++) begin
      c = 1'($urandom_range(0, 1));
      cycle(1, 64'h200 + idx, c);
      if (s_ready) idx++;
    end
    for (int n = 0; n < 40; n++) cycle(0, 0, m_cred < CREDITS);
    chk("t4_drained", s_cnt, 0);

    // credit overflow is sticky until reset
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    chk("t5_err_set", s_err, 1);
    chk("t5_cred_sat", s_cred, CREDITS);
    repeat (3) cycle(0, 0, 0);
    chk("t5_err_sticky", s_err, 1);
    do_reset();
    cycle(0, 0, 0);
    chk("t5_err_cleared", s_err, 0);

    // send and credit return in the same cycle at one credit
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      c = (m_fifo.size() != 0) && (m_cred == 1);
      cycle(1, 64'h300 + n, c);
      if (c) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_found", found, 1);
    cycle(1, 64'h3A0, 0);
    chk("t6_cred_kept", s_cred, 1);
    chk("t6_valid", s_valid, 1);
    cycle(1, 64'h3A1, 0);
    chk("t6_next_launch", s_valid, 1);

    // asynchronous reset mid-stream
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", noc_valid, 0);
    chk("t6_rst_data", noc_data, 0);
    chk("t6_rst_cred", credits_avail, CREDITS);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_err", credit_err, 0);
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(0, 0, 0);

    // random traffic
    held = 1'b0;
    v = 1'b0;
    d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        v = 1'($urandom_range(0, 1));
        d = {$urandom, $urandom};
      end
      c = (($urandom_range(0, 99) < 40) && (m_cred < CREDITS)) || ($urandom_range(0, 199) == 0);
      cycle(v, d, c);
      held = v && !s_ready;
    end
    for (int n = 0; n < 20; n++) cycle(0, 0, m_cred < CREDITS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
